minero_nonce_param: RTL and testbench
=====================================

MINERO_NONCE_PARAM -- requirements
Module: minero_nonce_param

Interface
REQ-001 SHALL have parameter NONCE_W, default 32: width of nonce counter and nonce ports.
REQ-002 SHALL have parameter N_TGT_BYTES, default 2, legal 1..3: number of most-significant hash bytes compared against target.
REQ-003 SHALL have parameter HASH_LAT, default 1, legal 1..4: hash sub-module pipeline depth in cycles.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port inicio  input  1  level start request.
REQ-007 SHALL have port bloque_bytes  input  96  block header to hash.
REQ-008 SHALL have port target  input  8  per-byte difficulty threshold.
REQ-009 SHALL have port nonce_max  input  NONCE_W  last nonce to try, inclusive.
REQ-010 SHALL have port ocupado  output  1  high while searching or draining.
REQ-011 SHALL have port terminado  output  1  search finished, held until release.
REQ-012 SHALL have port encontrado  output  1  valid with terminado; 1 = hit, 0 = exhausted/aborted.
REQ-013 SHALL have port hash  output  24  winning hash; 0 when encontrado=0.
REQ-014 SHALL have port nonce_out  output  NONCE_W  winning nonce; 0 when encontrado=0.

Function
REQ-015 SHALL implement FSM states IDLE, BUSCA, VACIA, FIN.
REQ-016 IDLE: inicio=1 SHALL latch bloque_bytes, target, nonce_max, clear nonce counter to 0, go to BUSCA next cycle.
REQ-017 BUSCA: SHALL issue one nonce per cycle to the hash pipeline, tagged valid with its nonce, counter +1 per cycle.
REQ-018 Hit SHALL be: each of the top N_TGT_BYTES bytes of the pipeline output strictly less than latched target, with valid tag set.
REQ-019 Nonce issued in cycle t SHALL produce its compare in cycle t+HASH_LAT; on hit, terminado, encontrado, hash, nonce_out SHALL register at t+HASH_LAT+1 and FSM SHALL enter FIN.
REQ-020 On hit, in-flight pipeline entries SHALL be discarded; the lowest hitting nonce SHALL win.
REQ-021 When the issued nonce equals nonce_max, issuing SHALL stop and FSM SHALL enter VACIA; counter SHALL NOT wrap.
REQ-022 VACIA: SHALL wait until the pipeline empties; a hit there follows REQ-019; no hit enters FIN with encontrado=0.
REQ-023 nonce_max=0 SHALL try exactly nonce 0.
REQ-024 FIN: outputs SHALL hold; FSM SHALL return to IDLE the cycle after inicio=0, clearing terminado and encontrado.
REQ-025 inicio changes during BUSCA/VACIA and a held inicio in FIN SHALL be ignored; no restart until inicio is seen low.
REQ-026 ocupado SHALL be 1 exactly in BUSCA and VACIA.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, clear all outputs, counter and pipeline valid tags to 0, in any state, including mid-search.
REQ-028 First inicio SHALL be honoured the cycle after reset deasserts.

Configuration
REQ-029 With ABORT_EN defined, SHALL add input abortar (1 bit); abortar=1 in BUSCA/VACIA SHALL enter FIN with encontrado=0, hash=0, nonce_out=0 next cycle; abortar ignored in IDLE/FIN.
REQ-030 Without ABORT_EN, port abortar SHALL be absent and behaviour SHALL be as REQ-015..026.

Structure
REQ-031 Package minero_pkg SHALL hold the FSM state enum, HASH_W=24, BLOQUE_W=96, TGT_W=8.
REQ-032 One sub-module, hash_core_ucr, SHALL compute the team's micro-UCR 24-bit hash of {bloque, nonce} with HASH_LAT register stages and a pass-through valid/nonce tag.

Verification
REQ-033 target=8'h00, nonce_max=15, HASH_LAT=1: 16 nonces issued, terminado=1, encontrado=0 at cycle 18 after inicio; hash=0.
REQ-034 target=8'hFF, N_TGT_BYTES=1, reference-model bloque whose nonce 0 hashes to top byte < FF: encontrado=1, nonce_out=0, terminado at cycle HASH_LAT+2.
REQ-035 Reference model finds first hit at nonce 37, nonce_max=100, HASH_LAT=3: nonce_out=37, hash matches model, no later nonce reported.
REQ-036 Hit only at nonce_max=20: hit reported from VACIA, encontrado=1, nonce_out=20.
REQ-037 reset pulsed at search cycle 5: all outputs 0 next cycle; new inicio restarts at nonce 0.
REQ-038 ABORT_EN, abortar at search cycle 4: terminado=1, encontrado=0 next cycle; inicio low returns IDLE.

Source files
------------

// File: rtl/minero_pkg.sv
// -----------------------------------------------------------------------------
// minero_pkg
// Shared definitions for the nonce-search miner:
//   - estado_t : search FSM states (IDLE, BUSCA, VACIA, FIN)
//   - HASH_W, BLOQUE_W, TGT_W : hash, block header and target widths
//   - ucr_hash : the micro-UCR 24-bit hash of {bloque, nonce32}
//
// micro-UCR hash definition:
//   The message is the 128-bit word {bloque[95:0], nonce32[31:0]}, split
//   into 16 bytes, byte 0 being the least significant (nonce LSB first).
//   Starting from h = UCR_IV, for each byte b in order:
//       x = h ^ {b, b, b}
//       h = rotl24(x, 7) + (x >> 3) + UCR_K      (mod 2^24)
// -----------------------------------------------------------------------------
package minero_pkg;

    localparam int HASH_W   = 24;
    localparam int BLOQUE_W = 96;
    localparam int TGT_W    = 8;

    localparam logic [HASH_W-1:0] UCR_IV = 24'h5A3C96;
    localparam logic [HASH_W-1:0] UCR_K  = 24'h3779B9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSCA = 2'd1,
        VACIA = 2'd2,
        FIN   = 2'd3
    } estado_t;

    function automatic logic [HASH_W-1:0] ucr_hash(
        input logic [BLOQUE_W-1:0] bloque,
        input logic [31:0]         nonce32
    );
        logic [BLOQUE_W+31:0] msg;
        logic [HASH_W-1:0]    h;
        logic [HASH_W-1:0]    x;
        msg = {bloque, nonce32};
        h   = UCR_IV;
        for (int i = 0; i < (BLOQUE_W + 32) / 8; i++) begin
            x = h ^ {3{msg[8*i +: 8]}};
            h = {x[16:0], x[23:17]} + {3'b000, x[23:3]} + UCR_K;
        end
        return h;
    endfunction

endpackage

// File: rtl/hash_core_ucr.sv
// -----------------------------------------------------------------------------
// hash_core_ucr
// Pipelined micro-UCR hash of {bloque, nonce}. The hash is evaluated in the
// first stage and then carried through HASH_LAT register stages in total,
// together with a valid tag and the nonce that produced it.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high; clears the valid tags
//   flush      in   clears the valid tags (discard in-flight work)
//   vld_in     in   a nonce is being issued this cycle
//   nonce_in   in   NONCE_W issued nonce
//   bloque     in   BLOQUE_W latched block header
//   vld_out    out  valid tag of the last stage
//   nonce_out  out  nonce carried with the last stage
//   hash_out   out  HASH_W hash of the last stage
// -----------------------------------------------------------------------------
module hash_core_ucr
    import minero_pkg::*;
#(
    parameter int NONCE_W  = 32,
    parameter int HASH_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                vld_in,
    input  logic [NONCE_W-1:0]  nonce_in,
    input  logic [BLOQUE_W-1:0] bloque,
    output logic                vld_out,
    output logic [NONCE_W-1:0]  nonce_out,
    output logic [HASH_W-1:0]   hash_out
);

    // The hash always consumes a 32-bit nonce field; narrower counters are
    // zero-extended, wider ones contribute only their low 32 bits.
    logic [31:0] nonce_w32;
    assign nonce_w32 = 32'(nonce_in);

    logic                vld_p   [HASH_LAT];
    logic [NONCE_W-1:0]  nonce_p [HASH_LAT];
    logic [HASH_W-1:0]   hash_p  [HASH_LAT];

    // ---- stage 0 .. HASH_LAT-1 : valid tags (control, resettable) ----
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < HASH_LAT; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= vld_in;
            for (int i = 1; i < HASH_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // ---- stage 0 .. HASH_LAT-1 : hash and nonce data ----
    always_ff @(posedge clk) begin
        hash_p[0]  <= ucr_hash(bloque, nonce_w32);
        nonce_p[0] <= nonce_in;
        for (int i = 1; i < HASH_LAT; i++) begin
            hash_p[i]  <= hash_p[i-1];
            nonce_p[i] <= nonce_p[i-1];
        end
    end

    assign vld_out   = vld_p[HASH_LAT-1];
    assign nonce_out = nonce_p[HASH_LAT-1];
    assign hash_out  = hash_p[HASH_LAT-1];

endmodule

// File: rtl/minero_nonce_param.sv
// -----------------------------------------------------------------------------
// minero_nonce_param
// Nonce search engine. On inicio it latches a block header, a per-byte
// target and the last nonce to try, then issues nonces 0, 1, 2, ... one per
// cycle into hash_core_ucr. A hash hits when each of its top N_TGT_BYTES
// bytes is strictly below the target. The first (lowest) hitting nonce is
// reported; if none hits up to nonce_max the search ends with encontrado=0.
//
// Optional feature: define ABORT_EN to add the abortar input, which ends an
// active search (BUSCA/VACIA) with encontrado=0 on the next cycle.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   inicio        in   level start request (must be seen low between runs)
//   bloque_bytes  in   96-bit block header
//   target        in   8-bit per-byte threshold
//   nonce_max     in   NONCE_W last nonce to try, inclusive
//   abortar       in   (ABORT_EN only) abort the active search
//   ocupado       out  high while searching (BUSCA) or draining (VACIA)
//   terminado     out  search finished; held until inicio drops
//   encontrado    out  1 = hit, 0 = exhausted/aborted (valid with terminado)
//   hash          out  24-bit winning hash, 0 when encontrado=0
//   nonce_out     out  NONCE_W winning nonce, 0 when encontrado=0
// -----------------------------------------------------------------------------
module minero_nonce_param
    import minero_pkg::*;
#(
    parameter int NONCE_W     = 32,
    parameter int N_TGT_BYTES = 2,
    parameter int HASH_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inicio,
    input  logic [BLOQUE_W-1:0] bloque_bytes,
    input  logic [TGT_W-1:0]    target,
    input  logic [NONCE_W-1:0]  nonce_max,
`ifdef ABORT_EN
    input  logic                abortar,
`endif
    output logic                ocupado,
    output logic                terminado,
    output logic                encontrado,
    output logic [HASH_W-1:0]   hash,
    output logic [NONCE_W-1:0]  nonce_out
);

    localparam int N_HASH_BYTES = HASH_W / 8;

    // True when every one of the top N_TGT_BYTES bytes of h is below t.
    function automatic logic hash_hit(
        input logic [HASH_W-1:0] h,
        input logic [TGT_W-1:0]  t
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_HASH_BYTES; i++) begin
            if (i < N_TGT_BYTES && !(h[HASH_W-1-8*i -: 8] < t)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    estado_t              estado;
    logic [BLOQUE_W-1:0]  blk_q;
    logic [TGT_W-1:0]     tgt_q;
    logic [NONCE_W-1:0]   max_q;
    logic [NONCE_W-1:0]   cnt;
    logic [2:0]           drain;

    logic                 issue_vld;
    logic                 h_vld;
    logic [NONCE_W-1:0]   h_nonce;
    logic [HASH_W-1:0]    h_hash;
    logic                 hit;
    logic                 activo;
    logic                 abort_req;
    logic                 flush;

`ifdef ABORT_EN
    assign abort_req = abortar;
`else
    assign abort_req = 1'b0;
`endif

    assign issue_vld = (estado == BUSCA);
    assign activo    = (estado == BUSCA) || (estado == VACIA);
    assign hit       = h_vld && hash_hit(h_hash, tgt_q);
    // Anything still in flight behind a hit (or at an abort) is dropped so
    // that it can never leak into the next search.
    assign flush     = activo && (hit || abort_req);

    hash_core_ucr #(
        .NONCE_W  (NONCE_W),
        .HASH_LAT (HASH_LAT)
    ) u_hash (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .vld_in    (issue_vld),
        .nonce_in  (cnt),
        .bloque    (blk_q),
        .vld_out   (h_vld),
        .nonce_out (h_nonce),
        .hash_out  (h_hash)
    );

    // ---- issue stage : search parameters captured at start ----
    always_ff @(posedge clk) begin
        if (estado == IDLE && inicio) begin
            blk_q <= bloque_bytes;
            tgt_q <= target;
            max_q <= nonce_max;
        end
    end

    // ---- control FSM with registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= IDLE;
            cnt        <= '0;
            drain      <= '0;
            ocupado    <= 1'b0;
            terminado  <= 1'b0;
            encontrado <= 1'b0;
            hash       <= '0;
            nonce_out  <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        cnt     <= '0;
                        ocupado <= 1'b1;
                        estado  <= BUSCA;
                    end
                end

                BUSCA, VACIA: begin
                    if (abort_req) begin
                        estado     <= FIN;
                        ocupado    <= 1'b0;
                        terminado  <= 1'b1;
                        encontrado <= 1'b0;
                        hash       <= '0;
                        nonce_out  <= '0;
                    end else if (hit) begin
                        estado     <= FIN;
                        ocupado    <= 1'b0;
                        terminado  <= 1'b1;
                        encontrado <= 1'b1;
                        hash       <= h_hash;
                        nonce_out  <= h_nonce;
                    end else if (estado == BUSCA) begin
                        // The counter stops on nonce_max so it never wraps.
                        if (cnt == max_q) begin
                            estado <= VACIA;
                            drain  <= 3'(HASH_LAT - 1);
                        end else begin
                            cnt <= cnt + NONCE_W'(1);
                        end
                    end else begin
                        // drain counts the cycles until the last issued
                        // nonce reaches the compare; at zero it is there now.
                        if (drain == 3'd0) begin
                            estado     <= FIN;
                            ocupado    <= 1'b0;
                            terminado  <= 1'b1;
                            encontrado <= 1'b0;
                            hash       <= '0;
                            nonce_out  <= '0;
                        end else begin
                            drain <= drain - 3'd1;
                        end
                    end
                end

                FIN: begin
                    if (!inicio) begin
                        estado     <= IDLE;
                        terminado  <= 1'b0;
                        encontrado <= 1'b0;
                        hash       <= '0;
                        nonce_out  <= '0;
                    end
                end

                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minero_nonce_param.sv
// -----------------------------------------------------------------------------
// tb_minero_nonce_param
// Self-checking bench for minero_nonce_param. A behavioural model computes
// the micro-UCR hash with plain integer arithmetic, scans nonces 0..nonce_max
// for the first hit and predicts the result and the cycle terminado rises.
// Optional ABORT_EN feature is exercised when the macro is defined.
// -----------------------------------------------------------------------------
module tb_minero_nonce_param;

    localparam int NW  = 32;
    localparam int NTB = 2;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          inicio;
    logic [95:0]   bloque_bytes;
    logic [7:0]    target;
    logic [NW-1:0] nonce_max;
    logic          abortar;
    logic          ocupado;
    logic          terminado;
    logic          encontrado;
    logic [23:0]   hash;
    logic [NW-1:0] nonce_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    minero_nonce_param #(
        .NONCE_W     (NW),
        .N_TGT_BYTES (NTB),
        .HASH_LAT    (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .bloque_bytes (bloque_bytes),
        .target       (target),
        .nonce_max    (nonce_max),
`ifdef ABORT_EN
        .abortar      (abortar),
`endif
        .ocupado      (ocupado),
        .terminado    (terminado),
        .encontrado   (encontrado),
        .hash         (hash),
        .nonce_out    (nonce_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned ref_hash(input logic [95:0] blk, input int unsigned n);
        logic [127:0] m;
        int unsigned  h, x, b;
        m = {blk, n};
        h = 32'h5A3C96;
        for (int i = 0; i < 16; i++) begin
            b = int'(m[8*i +: 8]);
            x = h ^ (b * 32'h010101);
            h = (((x << 7) | (x >> 17)) + (x >> 3) + 32'h3779B9) & 32'hFFFFFF;
        end
        return h;
    endfunction

    function automatic bit ref_hit(input int unsigned h, input int unsigned tgt);
        for (int j = 0; j < NTB; j++) begin
            if (((h >> (16 - 8*j)) & 32'hFF) >= tgt) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int first_hit(input logic [95:0] blk, input logic [7:0] tgt, input int unsigned nmax);
        for (int unsigned n = 0; n <= nmax; n++) begin
            if (ref_hit(ref_hash(blk, n), tgt)) return int'(n);
        end
        return -1;
    endfunction

    function automatic logic [95:0] rnd_blk();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Random block whose first hit (scanning up to 'limit') is exactly 'want'.
    function automatic logic [95:0] find_block(input logic [7:0] tgt, input int want, input int unsigned limit);
        logic [95:0] b;
        for (int t = 0; t < 4000; t++) begin
            b = rnd_blk();
            if (first_hit(b, tgt, limit) == want) return b;
        end
        return b;
    endfunction

    // Caller must be just after a negedge. Starts a search, tracks it to
    // terminado, checks the result, the hold in FIN and the return to IDLE.
    task automatic run_search(input logic [95:0] blk, input logic [7:0] tgt,
                              input int unsigned nmax, input string tag);
        int k, lat, gaps, budget;
        int unsigned exp_h, exp_n, exp_lat;
        bit exp_f;
        k      = first_hit(blk, tgt, nmax);
        exp_f  = (k >= 0);
        exp_n  = exp_f ? k : 0;
        exp_h  = exp_f ? ref_hash(blk, k) : 0;
        exp_lat = (exp_f ? k : nmax) + LAT + 1;
        budget = nmax + LAT + 12;

        bloque_bytes = blk;
        target       = tgt;
        nonce_max    = nmax;
        inicio       = 1'b1;
        lat  = -1;
        gaps = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (terminado) begin
                lat = i;
                break;
            end
            if (!ocupado) gaps++;
            @(negedge clk);
            inicio = 1'($urandom_range(0, 1));
        end
        if (lat < 0) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            @(negedge clk); reset = 1'b1; inicio = 1'b0;
            @(negedge clk); reset = 1'b0;
            return;
        end
        chk({tag, "_latency"},    lat, exp_lat);
        chk({tag, "_busy_gaps"},  gaps, 0);
        chk({tag, "_encontrado"}, encontrado, exp_f);
        chk({tag, "_hash"},       hash, exp_h);
        chk({tag, "_nonce"},      nonce_out, exp_n);
        chk({tag, "_ocupado"},    ocupado, 1'b0);
        // held inicio in FIN is ignored
        @(negedge clk); inicio = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_hold_term"},  terminado, 1'b1);
        chk({tag, "_hold_nonce"}, nonce_out, exp_n);
        @(negedge clk); inicio = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_term"},  terminado, 1'b0);
        chk({tag, "_idle_enc"},   encontrado, 1'b0);
        chk({tag, "_idle_hash"},  hash, 24'h0);
        chk({tag, "_idle_ocup"},  ocupado, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ocupado"},    ocupado, 1'b0);
        chk({tag, "_terminado"},  terminado, 1'b0);
        chk({tag, "_encontrado"}, encontrado, 1'b0);
        chk({tag, "_hash"},       hash, 24'h0);
        chk({tag, "_nonce"},      nonce_out, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] b0, b37, b20;
        reset        = 1'b1;
        inicio       = 1'b0;
        abortar      = 1'b0;
        bloque_bytes = '0;
        target       = '0;
        nonce_max    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");

        b0  = find_block(8'hFF, 0, 0);
        b37 = find_block(8'h20, 37, 100);
        b20 = find_block(8'h20, 20, 20);

        // first inicio on the cycle right after reset deasserts
        @(negedge clk); reset = 1'b0;
        run_search(rnd_blk(), 8'h00, 15, "exhaust15");
        @(negedge clk); run_search(b0,  8'hFF, 40,  "hit0");
        @(negedge clk); run_search(b37, 8'h20, 100, "hit37");
        @(negedge clk); run_search(b20, 8'h20, 20,  "hit_at_max");
        @(negedge clk); run_search(rnd_blk(), 8'h00, 0, "nmax0_miss");
        @(negedge clk); run_search(b0,  8'hFF, 0,   "nmax0_hit");

        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            run_search(rnd_blk(), 8'($urandom_range(0, 255)), $urandom_range(0, 60), "rand");
        end

        // reset in the middle of a search
        @(negedge clk);
        bloque_bytes = rnd_blk(); target = 8'h00; nonce_max = 1000; inicio = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1; inicio = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        @(negedge clk); reset = 1'b0;
        run_search(b0, 8'hFF, 30, "restart");

`ifdef ABORT_EN
        @(negedge clk);
        bloque_bytes = rnd_blk(); target = 8'h00; nonce_max = 500; inicio = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); abortar = 1'b1;
        @(posedge clk); #1;
        chk("abort_term", terminado, 1'b1);
        chk("abort_enc",  encontrado, 1'b0);
        chk("abort_hash", hash, 24'h0);
        chk("abort_nonce", nonce_out, '0);
        chk("abort_ocup", ocupado, 1'b0);
        @(negedge clk); abortar = 1'b0; inicio = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_term", terminado, 1'b0);
        // abortar in IDLE has no effect on the next search
        @(negedge clk); abortar = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_ignored", terminado, 1'b0);
        @(negedge clk); abortar = 1'b0;
        run_search(b37, 8'h20, 100, "after_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
